csr_req_responder: RTL
======================

// Module: csr_req_responder
// PURPOSE
//  Slave end of the CSR request interface. Sits in the issue->CSR path of a core.
//  Accepts one CSR instruction per cycle and reads the addressed per-warp CSR.
//  Computes the RW/RS/RC update and writes it back, then returns the old value
//  on a commit stream, replicated across the active threads.
// PARAMETERS
//  NUM_THREADS   4   threads per warp; commit data lanes
//  NUM_WARPS     4   warps; NW_BITS = clog2(NUM_WARPS)
//  UUID_BITS     44  instruction uuid width
//  NR_BITS       6   destination register index width
//  NRI_BITS      5   CSR immediate width (zero-extended)
//  CSR_ADDR_BITS 12  CSR address width
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  asynchronous, active-high
//  req_valid    in   1                  request valid
//  req_uuid     in   UUID_BITS          instruction uuid
//  req_wid      in   NW_BITS            warp id
//  req_tmask    in   NUM_THREADS        active threads
//  req_PC       in   32                 instruction PC
//  req_op_type  in   INST_CSR_BITS(2)   RW/RS/RC
//  req_addr     in   CSR_ADDR_BITS      CSR address
//  req_rs1_data in   32                 register operand
//  req_use_imm  in   1                  select immediate operand
//  req_imm      in   NRI_BITS           immediate operand
//  req_rd       in   NR_BITS            destination register
//  req_wb       in   1                  writeback enable
//  req_ready    out  1                  request accepted when valid&ready
//  csr_rd_addr  out  CSR_ADDR_BITS      CSR file read address (registered data next cycle)
//  csr_rd_wid   out  NW_BITS            CSR file read warp
//  csr_rd_data  in   32                 read data, 1 cycle after address
//  csr_wr_en    out  1                  CSR file write strobe
//  csr_wr_addr  out  CSR_ADDR_BITS      write address
//  csr_wr_wid   out  NW_BITS            write warp
//  csr_wr_data  out  32                 write data
//  cmt_valid    out  1                  commit valid
//  cmt_uuid/wid/tmask/PC/rd/wb  out  as req  passed through unchanged
//  cmt_data     out  NUM_THREADS*32     old CSR value in every lane
//  cmt_ready    in   1                  commit consumer ready
// BEHAVIOUR
//  - Reset (async): s0/s1 valid=0, buffer empty, cmt_valid=0, csr_wr_en=0, req_ready=0 while reset is high.
//  - S0 (accept): on req_valid&req_ready, drive csr_rd_addr/wid combinationally from req and latch the fields into S1.
//  - S1 (execute): old = fwd_hit ? fwd_data : csr_rd_data.
//  - Operand: op = use_imm ? zext(imm) : rs1_data.
//  - Update: RW: new=op; RS: new=old|op; RC: new=old&~op. Op codes come from the package (RW=1, RS=2, RC=3).
//  - Write: csr_wr_en=1 in the S1 cycle that pushes to the buffer, except in these cases:
//    (a) RS/RC with op==0;
//    (b) addr[11:10]==2'b11 (read-only);
//    (c) op_type is not RW/RS/RC, which is illegal. For illegal op_type, commit still happens with old data.
//  - Forwarding: when S0 accepts in the same cycle that S1 writes the same {wid,addr}, set fwd_hit=1 and fwd_data=new. This handles back-to-back same-CSR requests.
//  - Commit buffer: 2-entry FIFO. cmt_* are driven from the head entry.
//    S1 pushes when S1 is valid and the buffer is not full; pop on cmt_valid&cmt_ready.
//    Simultaneous push and pop at full is not allowed (push needs ~full).
//  - Stall: S1 holds while the buffer is full. req_ready = ~s1_valid | s1_push.
//    A held S1 must not re-read the CSR: the read value is captured into an S1 data register on its first cycle.
//  - cmt_data gets old; tmask is passed through and lanes are not masked.
//  - Latency: accept to cmt_valid = 2 cycles when unstalled. Throughput 1/cycle.
//  - Reset mid-op: all in-flight requests are dropped and no write is issued.
// STRUCTURE
//  - Package VX_csr_pkg: INST_CSR_BITS, CSR_OP_RW/RS/RC, CSR_ADDR_BITS, CSR_RO_PREFIX, and a commit-entry struct typedef.
//  - Sub-module: csr_cmt_fifo (2-entry elastic buffer, parameterised width).
// TESTING
//  - Single RW request (wid 1, addr 0x7C0, rs1 0xDEAD_BEEF), CSR holds 0x1234:
//    cmt_data = 0x1234 in all lanes 2 cycles later; wr 0xDEADBEEF once.
//  - RS with use_imm, imm=5, old 0x10: write 0x15.
//    RC with rs1 0x0F, old 0xFF: write 0xF0. RS with imm 0: no csr_wr_en, cmt_data=old.
//  - Back-to-back RS 0x1, then RS 0x2, same wid/addr, old 0: second cmt_data=0x1 and second write 0x3 (forward).
//    Same pair on different wid: no forward.
//  - Write to 0xC00 (RO) with RW: csr_wr_en stays 0; commit returns the read value.
//  - Hold cmt_ready=0 for 5 cycles with a stream of 4 requests: 2 buffered, S1 held, req_ready=0.
//    On release, commits arrive in order, each writes once, and data is unchanged.
//  - Assert reset with 2 entries in flight: cmt_valid=0 and csr_wr_en=0 immediately.
//    After release, req_ready=1 and there are no ghost commits.

Source files
------------

// File: rtl/VX_csr_pkg.sv
// CSR request responder shared definitions.
// Op encodings, address classes and the commit entry layout.
package VX_csr_pkg;

    localparam int INST_CSR_BITS = 2;
    localparam int CSR_ADDR_BITS = 12;

    localparam logic [INST_CSR_BITS-1:0] CSR_OP_RW = 2'd1;
    localparam logic [INST_CSR_BITS-1:0] CSR_OP_RS = 2'd2;
    localparam logic [INST_CSR_BITS-1:0] CSR_OP_RC = 2'd3;

    localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

    typedef struct packed {
        logic [43:0] uuid;
        logic [1:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic        wb;
        logic [31:0] data;
    } csr_cmt_entry_t;

    function automatic logic csr_is_ro(
        input logic [CSR_ADDR_BITS-1:0] addr
    );
        return addr[CSR_ADDR_BITS-1 -: 2] == CSR_RO_PREFIX;
    endfunction

endpackage

// File: rtl/csr_cmt_fifo.sv
// Two-entry elastic buffer for CSR commits.
// Push is ignored when full; pop is ignored when empty.
module csr_cmt_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    // Occupancy follows the accepted push/pop pair.
    always_comb begin
        cnt_d = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/csr_req_responder.sv
// CSR request responder: read, RW/RS/RC update, write-back, commit.
// Two stages (accept, execute) feeding a 2-entry commit buffer.
module csr_req_responder
    import VX_csr_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int UUID_BITS   = 44,
    parameter int NR_BITS     = 6,
    parameter int NRI_BITS    = 5,
    parameter int NW_BITS     = $clog2(NUM_WARPS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    input  logic [UUID_BITS-1:0]       req_uuid,
    input  logic [NW_BITS-1:0]         req_wid,
    input  logic [NUM_THREADS-1:0]     req_tmask,
    input  logic [31:0]                req_PC,
    input  logic [INST_CSR_BITS-1:0]   req_op_type,
    input  logic [CSR_ADDR_BITS-1:0]   req_addr,
    input  logic [31:0]                req_rs1_data,
    input  logic                       req_use_imm,
    input  logic [NRI_BITS-1:0]        req_imm,
    input  logic [NR_BITS-1:0]         req_rd,
    input  logic                       req_wb,
    output logic                       req_ready,
    output logic [CSR_ADDR_BITS-1:0]   csr_rd_addr,
    output logic [NW_BITS-1:0]         csr_rd_wid,
    input  logic [31:0]                csr_rd_data,
    output logic                       csr_wr_en,
    output logic [CSR_ADDR_BITS-1:0]   csr_wr_addr,
    output logic [NW_BITS-1:0]         csr_wr_wid,
    output logic [31:0]                csr_wr_data,
    output logic                       cmt_valid,
    output logic [UUID_BITS-1:0]       cmt_uuid,
    output logic [NW_BITS-1:0]         cmt_wid,
    output logic [NUM_THREADS-1:0]     cmt_tmask,
    output logic [31:0]                cmt_PC,
    output logic [NR_BITS-1:0]         cmt_rd,
    output logic                       cmt_wb,
    output logic [NUM_THREADS*32-1:0]  cmt_data,
    input  logic                       cmt_ready
);

    localparam int EW = UUID_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + 1 + 32;

    logic                      s1_valid_q;
    logic                      s1_first_q;
    logic [UUID_BITS-1:0]      s1_uuid_q;
    logic [NW_BITS-1:0]        s1_wid_q;
    logic [NUM_THREADS-1:0]    s1_tmask_q;
    logic [31:0]               s1_pc_q;
    logic [INST_CSR_BITS-1:0]  s1_op_q;
    logic [CSR_ADDR_BITS-1:0]  s1_addr_q;
    logic [31:0]               s1_opnd_q;
    logic [NR_BITS-1:0]        s1_rd_q;
    logic                      s1_wb_q;
    logic                      s1_fwd_hit_q;
    logic [31:0]               s1_fwd_data_q;
    logic [31:0]               s1_data_q;

    logic [31:0]               s1_old;
    logic [31:0]               s1_new;
    logic                      s1_legal;
    logic                      s1_zero_skip;
    logic                      s1_push;
    logic                      accept;
    logic                      fwd_hit_d;
    logic [31:0]               req_opnd;
    logic                      fifo_full;
    logic [EW-1:0]             fifo_in;
    logic [EW-1:0]             fifo_out;
    logic [31:0]               cmt_old;

    assign s1_push   = s1_valid_q & ~fifo_full;
    assign req_ready = ~reset & (~s1_valid_q | s1_push);
    assign accept    = req_valid & req_ready;

    assign csr_rd_addr = req_addr;
    assign csr_rd_wid  = req_wid;

    assign req_opnd = req_use_imm ? {{(32 - NRI_BITS){1'b0}}, req_imm}
                                  : req_rs1_data;

    // A held S1 uses its captured read value, never the live read port.
    assign s1_old = ~s1_first_q   ? s1_data_q :
                    s1_fwd_hit_q  ? s1_fwd_data_q : csr_rd_data;

    // Update value and legality of the executing op.
    always_comb begin
        s1_new   = s1_old;
        s1_legal = 1'b0;
        case (s1_op_q)
            CSR_OP_RW: begin
                s1_new   = s1_opnd_q;
                s1_legal = 1'b1;
            end
            CSR_OP_RS: begin
                s1_new   = s1_old | s1_opnd_q;
                s1_legal = 1'b1;
            end
            CSR_OP_RC: begin
                s1_new   = s1_old & ~s1_opnd_q;
                s1_legal = 1'b1;
            end
            default: begin
                s1_new   = s1_old;
                s1_legal = 1'b0;
            end
        endcase
    end

    assign s1_zero_skip = (s1_op_q != CSR_OP_RW) && (s1_opnd_q == 32'd0);

    assign csr_wr_en   = s1_push & s1_legal & ~s1_zero_skip
                       & ~csr_is_ro(s1_addr_q);
    assign csr_wr_addr = s1_addr_q;
    assign csr_wr_wid  = s1_wid_q;
    assign csr_wr_data = s1_new;

    assign fwd_hit_d = accept & csr_wr_en
                     & (req_wid == s1_wid_q) & (req_addr == s1_addr_q);

    // Execute-stage register: load on accept, drop on push, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q    <= 1'b0;
            s1_first_q    <= 1'b0;
            s1_uuid_q     <= '0;
            s1_wid_q      <= '0;
            s1_tmask_q    <= '0;
            s1_pc_q       <= '0;
            s1_op_q       <= '0;
            s1_addr_q     <= '0;
            s1_opnd_q     <= '0;
            s1_rd_q       <= '0;
            s1_wb_q       <= 1'b0;
            s1_fwd_hit_q  <= 1'b0;
            s1_fwd_data_q <= '0;
            s1_data_q     <= '0;
        end else begin
            s1_first_q <= accept;
            if (s1_valid_q && s1_first_q) begin
                s1_data_q <= s1_old;
            end
            if (accept) begin
                s1_valid_q    <= 1'b1;
                s1_uuid_q     <= req_uuid;
                s1_wid_q      <= req_wid;
                s1_tmask_q    <= req_tmask;
                s1_pc_q       <= req_PC;
                s1_op_q       <= req_op_type;
                s1_addr_q     <= req_addr;
                s1_opnd_q     <= req_opnd;
                s1_rd_q       <= req_rd;
                s1_wb_q       <= req_wb;
                s1_fwd_hit_q  <= fwd_hit_d;
                s1_fwd_data_q <= s1_new;
            end else if (s1_push) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign fifo_in = {s1_uuid_q, s1_wid_q, s1_tmask_q, s1_pc_q,
                      s1_rd_q, s1_wb_q, s1_old};

    csr_cmt_fifo #(
        .WIDTH (EW)
    ) u_cmt_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (s1_push),
        .data_i  (fifo_in),
        .pop_i   (cmt_ready),
        .full_o  (fifo_full),
        .valid_o (cmt_valid),
        .data_o  (fifo_out)
    );

    assign {cmt_uuid, cmt_wid, cmt_tmask, cmt_PC,
            cmt_rd, cmt_wb, cmt_old} = fifo_out;
    assign cmt_data = {NUM_THREADS{cmt_old}};

endmodule
